// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution core sequencer family:
// FSM encoding, default widths and the maxpool reduction factor.
package conv_ctrl_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int STEP_W_DEF = 3;
    localparam int MP_DIV     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/conv_core_sequencer_if.sv
// Window-buffer handshake and arithmetic-core control bundle.
// master = sequencer side, slave = buffer/core side.
interface conv_core_sequencer_if
    import conv_ctrl_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STEP_W = STEP_W_DEF
);
    logic              win_valid;
    logic              win_ready;
    logic [CNT_W-1:0]  win_addr;
    logic [STEP_W-1:0] win_step;
    logic              core_en;
    logic [STEP_W-1:0] core_step;
    logic [1:0]        core_bound_level;
    logic              core_en_relu;
    logic              core_en_mp;
    logic              core_out_en;

    modport master (
        input  win_valid, core_out_en,
        output win_ready, win_addr, win_step,
        output core_en, core_step, core_bound_level, core_en_relu, core_en_mp
    );

    modport slave (
        output win_valid, core_out_en,
        input  win_ready, win_addr, win_step,
        input  core_en, core_step, core_bound_level, core_en_relu, core_en_mp
    );

endinterface

// File: rtl/step_pixel_counter.sv
// Nested step/pixel counter: the step index wraps at i_n_step and then bumps
// the pixel index; o_last flags the final (pixel, step) pair of a job.
module step_pixel_counter #(
    parameter int CNT_W  = 16,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_advance,
    input  logic [STEP_W-1:0] i_n_step,
    input  logic [CNT_W-1:0]  i_n_out,
    output logic [STEP_W-1:0] o_step,
    output logic [CNT_W-1:0]  o_addr,
    output logic              o_last
);

    logic [STEP_W-1:0] r_step;
    logic [CNT_W-1:0]  r_addr;
    logic              w_step_wrap;

    assign w_step_wrap = (r_step == i_n_step);
    // i_n_out is never 0 while advancing, so the minus-one cannot underflow in use.
    assign o_last      = w_step_wrap && (r_addr == (i_n_out - CNT_W'(1)));
    assign o_step      = r_step;
    assign o_addr      = r_addr;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_step <= '0;
            r_addr <= '0;
        end else if (i_advance) begin
            if (w_step_wrap) begin
                r_step <= '0;
                r_addr <= r_addr + CNT_W'(1);
            end else begin
                r_step <= r_step + STEP_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_core_sequencer.sv
// Job-level controller for one PE/ReLU/maxpool core: issues windows, counts
// results, and ends the job on the expected count or on a drain timeout.
module conv_core_sequencer
    import conv_ctrl_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int STEP_W        = STEP_W_DEF,
    parameter int DRAIN_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_n_out,
    input  logic [STEP_W-1:0] cfg_n_step,
    input  logic [1:0]        cfg_bound_level,
    input  logic              cfg_relu,
    input  logic              cfg_mp,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  res_count,
    conv_core_sequencer_if.master bus
);

    localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_n_out;
    logic [STEP_W-1:0] r_n_step;
    logic [1:0]        r_bound;
    logic              r_relu;
    logic              r_mp;
    logic              r_busy;
    logic              r_err;
    logic [CNT_W-1:0]  r_res_count;
    logic [TO_W-1:0]   r_timeout;

    logic              w_accept;
    logic              w_issue;
    logic              w_counting;
    logic              w_transfer;
    logic              w_last;
    logic              w_done;
    logic              w_timeout_hit;
    logic              w_res_reached;
    logic [STEP_W-1:0] w_step;
    logic [CNT_W-1:0]  w_addr;
    logic [CNT_W-1:0]  w_expected;

    assign w_issue    = (r_state == ST_ISSUE);
    assign w_counting = w_issue || (r_state == ST_DRAIN);
    assign w_transfer = w_issue && bus.win_valid;
    assign w_expected = r_mp ? (r_n_out / CNT_W'(MP_DIV)) : r_n_out;
    // Compare against the held count so results landing during ISSUE still count.
    assign w_res_reached = (r_res_count >= w_expected);

    step_pixel_counter #(
        .CNT_W  (CNT_W),
        .STEP_W (STEP_W)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept),
        .i_advance (w_transfer),
        .i_n_step  (r_n_step),
        .i_n_out   (r_n_out),
        .o_step    (w_step),
        .o_addr    (w_addr),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_done        = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = (cfg_n_out == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_transfer && w_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_res_reached) begin
                    w_state_next = ST_DONE;
                end else if (r_timeout == TO_W'(DRAIN_TIMEOUT - 1)) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_n_out     <= '0;
            r_n_step    <= '0;
            r_bound     <= '0;
            r_relu      <= 1'b0;
            r_mp        <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_res_count <= '0;
            r_timeout   <= '0;
        end else begin
            if (w_accept) begin
                r_n_out     <= cfg_n_out;
                r_n_step    <= cfg_n_step;
                r_bound     <= cfg_bound_level;
                r_relu      <= cfg_relu;
                r_mp        <= cfg_mp;
                r_busy      <= 1'b1;
                r_err       <= 1'b0;
                r_res_count <= '0;
            end
            if (w_done) begin
                r_busy <= 1'b0;
            end
            if (w_counting && bus.core_out_en && (r_res_count != '1)) begin
                r_res_count <= r_res_count + CNT_W'(1);
            end
            // Held at zero during ISSUE so every DRAIN entry starts a fresh window.
            if (w_issue) begin
                r_timeout <= '0;
            end else if (r_state == ST_DRAIN) begin
                r_timeout <= r_timeout + TO_W'(1);
            end
            if (w_timeout_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = w_done;
    assign err_timeout = r_err;
    assign res_count   = r_res_count;

    assign bus.win_ready        = w_issue;
    assign bus.win_addr         = w_addr;
    assign bus.win_step         = w_step;
    assign bus.core_en          = w_transfer;
    assign bus.core_step        = w_step;
    assign bus.core_bound_level = r_bound;
    assign bus.core_en_relu     = r_relu;
    assign bus.core_en_mp       = r_mp;

endmodule

// File: tb/tb_conv_core_sequencer.sv
// Directed bench for conv_core_sequencer with a stub core that returns one
// result 3 cycles after every stub_div-th final-step issue.
module tb_conv_core_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] cfg_n_out;
    logic [2:0]  cfg_n_step;
    logic [1:0]  cfg_bound_level;
    logic        cfg_relu;
    logic        cfg_mp;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [15:0] res_count;

    always #5 clk = ~clk;

    conv_core_sequencer_if #(.CNT_W(16), .STEP_W(3)) bus ();

    conv_core_sequencer #(
        .CNT_W         (16),
        .STEP_W        (3),
        .DRAIN_TIMEOUT (15)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cfg_n_out       (cfg_n_out),
        .cfg_n_step      (cfg_n_step),
        .cfg_bound_level (cfg_bound_level),
        .cfg_relu        (cfg_relu),
        .cfg_mp          (cfg_mp),
        .busy            (busy),
        .done            (done),
        .err_timeout     (err_timeout),
        .res_count       (res_count),
        .bus             (bus)
    );

    // Stub core
    logic       stub_on   = 1'b1;
    int         stub_div  = 1;
    logic [2:0] stub_nstep = '0;
    int         fin_cnt   = 0;
    logic [2:0] r_pipe    = '0;
    logic       w_fin;

    assign w_fin           = bus.core_en && (bus.core_step == stub_nstep);
    assign bus.core_out_en = r_pipe[2];

    always @(posedge clk) begin
        if (start) fin_cnt <= 0;
        else if (w_fin) fin_cnt <= fin_cnt + 1;
        r_pipe <= {r_pipe[1:0], stub_on && w_fin && ((fin_cnt % stub_div) == stub_div - 1)};
    end

    int checks = 0;
    int errors = 0;

    // Per-job observations
    int q_step[$];
    int q_addr[$];
    int exp_step[$];
    int exp_addr[$];
    int n_en, n_done, en_bad, cfg_bad, drain_cyc, done_c, err_at_done, res_at_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic run_job(input logic [15:0] n_out, input logic [2:0] n_step,
                           input logic [1:0] bl, input logic relu, input logic mp,
                           input logic [3:0] vpat, input int rogue_c);
        cfg_n_out = n_out; cfg_n_step = n_step; cfg_bound_level = bl;
        cfg_relu = relu; cfg_mp = mp; stub_nstep = n_step;
        start = 1'b1; bus.win_valid = 1'b0;
        q_step.delete(); q_addr.delete(); exp_step.delete(); exp_addr.delete();
        for (int a = 0; a < n_out; a++)
            for (int s = 0; s <= n_step; s++) begin
                exp_addr.push_back(a); exp_step.push_back(s);
            end
        n_en = 0; n_done = 0; en_bad = 0; cfg_bad = 0; drain_cyc = 0;
        done_c = -1; err_at_done = -1; res_at_done = -1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            bus.win_valid = vpat[c % 4];
            if (c == rogue_c) begin
                start = 1'b1; cfg_n_out = 16'd5; cfg_n_step = ~n_step;
                cfg_bound_level = ~bl; cfg_relu = ~relu; cfg_mp = ~mp;
            end else if (c == rogue_c + 1) begin
                start = 1'b0; cfg_n_out = n_out; cfg_n_step = n_step;
                cfg_bound_level = bl; cfg_relu = relu; cfg_mp = mp;
            end
            @(negedge clk);
            if (bus.core_en) begin
                n_en++;
                q_step.push_back(int'(bus.core_step));
                q_addr.push_back(int'(bus.win_addr));
                if (!bus.win_valid || bus.core_step !== bus.win_step) en_bad++;
            end
            if (bus.win_valid && bus.win_ready && !bus.core_en) en_bad++;
            if (busy && (bus.core_en_relu !== relu || bus.core_en_mp !== mp ||
                         bus.core_bound_level !== bl)) cfg_bad++;
            if (busy && !bus.win_ready && !done && n_en > 0) drain_cyc++;
            if (done) begin
                n_done++;
                if (done_c < 0) done_c = c;
                err_at_done = int'(err_timeout);
                res_at_done = int'(res_count);
            end
            if (!busy) break;
            @(posedge clk); #1;
        end
        bus.win_valid = 1'b0;
        $display("job n_out=%0d n_step=%0d mp=%0d: en=%0d done=%0d at c=%0d res=%0d err=%0d",
                 n_out, n_step, mp, n_en, n_done, done_c, res_at_done, err_at_done);
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, q_step.size(), exp_step.size());
        for (int i = 0; i < q_step.size() && i < exp_step.size(); i++) begin
            chk($sformatf("%s_step%0d", tag, i), q_step[i], exp_step[i]);
            chk($sformatf("%s_addr%0d", tag, i), q_addr[i], exp_addr[i]);
        end
    endtask

    int done_seen;

    initial begin
        reset = 1'b1; start = 1'b0; cfg_n_out = '0; cfg_n_step = '0;
        cfg_bound_level = '0; cfg_relu = 1'b0; cfg_mp = 1'b0; bus.win_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", bus.win_ready, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_res", res_count, 16'd0);
        chk("rst_addr", bus.win_addr, 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic job
        stub_on = 1'b1; stub_div = 1;
        run_job(16'd3, 3'd1, 2'd1, 1'b1, 1'b0, 4'b1111, -1);
        chk("basic_en", n_en, 6);
        chk_seq("basic");
        chk("basic_res", res_at_done, 3);
        chk("basic_ndone", n_done, 1);
        chk("basic_done_c", done_c, 10);
        chk("basic_cfg", cfg_bad, 0);
        chk("basic_err", err_at_done, 0);

        // Stalls: valid pattern 1,0,0,1
        run_job(16'd3, 3'd1, 2'd1, 1'b1, 1'b0, 4'b1001, -1);
        chk("stall_en", n_en, 6);
        chk("stall_en_bad", en_bad, 0);
        chk_seq("stall");
        chk("stall_res", res_at_done, 3);
        chk("stall_ndone", n_done, 1);

        // Maxpool: 8 pixels -> 2 results
        stub_div = 4;
        run_job(16'd8, 3'd0, 2'd0, 1'b0, 1'b1, 4'b1111, -1);
        chk("mp_en", n_en, 8);
        chk("mp_res", res_at_done, 2);
        chk("mp_done_c", done_c, 12);
        chk("mp_err", err_at_done, 0);
        chk("mp_cfg", cfg_bad, 0);

        // Timeout: core never answers
        stub_on = 1'b0; stub_div = 1;
        run_job(16'd2, 3'd0, 2'd3, 1'b0, 1'b0, 4'b1111, -1);
        chk("to_drain", drain_cyc, 15);
        chk("to_err", err_at_done, 1);
        chk("to_ndone", n_done, 1);
        chk("to_res", res_at_done, 0);
        chk("to_sticky", err_timeout, 1'b1);

        // n_out = 0: immediate done, clears the sticky error
        stub_on = 1'b1;
        run_job(16'd0, 3'd2, 2'd0, 1'b0, 1'b0, 4'b1111, -1);
        chk("zero_done_c", done_c, 0);
        chk("zero_en", n_en, 0);
        chk("zero_err", err_at_done, 0);
        chk("zero_ndone", n_done, 1);

        // start while busy must be ignored
        run_job(16'd2, 3'd1, 2'd2, 1'b0, 1'b0, 4'b1111, 1);
        chk("rogue_en", n_en, 4);
        chk("rogue_cfg", cfg_bad, 0);
        chk("rogue_ndone", n_done, 1);
        chk("rogue_res", res_at_done, 2);

        // Reset mid-ISSUE
        cfg_n_out = 16'd4; cfg_n_step = 3'd3; cfg_bound_level = 2'd3;
        cfg_relu = 1'b1; cfg_mp = 1'b1; stub_nstep = 3'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bus.win_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        chk("mid_ready", bus.win_ready, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rsti_busy", busy, 1'b0);
        chk("rsti_done", done, 1'b0);
        chk("rsti_ready", bus.win_ready, 1'b0);
        chk("rsti_en", bus.core_en, 1'b0);
        chk("rsti_step", bus.win_step, 3'd0);
        chk("rsti_addr", bus.win_addr, 16'd0);
        chk("rsti_bl", bus.core_bound_level, 2'd0);
        chk("rsti_relu", bus.core_en_relu, 1'b0);
        chk("rsti_mp", bus.core_en_mp, 1'b0);
        reset = 1'b0; bus.win_valid = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("rsti_nodone", done_seen, 0);
        chk("rsti_idle_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
